// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding,
// the half-adder cell used to build the full-adder bit cell, and the
// bit-counter width helper.
package serial_adder_pkg;

    // Controller states. The unused code 2'b11 is treated as illegal and
    // steers back to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Output pair of one half-adder cell.
    typedef struct packed {
        logic s;
        logic c;
    } ha_t;

    // One half-adder cell: sum is XOR, carry is AND.
    function automatic ha_t half_add(input logic x, input logic y);
        ha_t r;
        r.s = x ^ y;
        r.c = x & y;
        return r;
    endfunction

    // Bit counter width: wide enough to hold N-1 for any N >= 1.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/bit_full_adder.sv
// Single-bit full adder assembled from two half-adder cells and an OR gate.
// Purely combinational; the serial adder uses exactly one of these.
module bit_full_adder
    import serial_adder_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    ha_t h1;
    ha_t h2;

    // First cell adds the operand bits, second adds the incoming carry;
    // at most one of the two cells can produce a carry, so OR merges them.
    always_comb begin
        h1 = half_add(x, y);
        h2 = half_add(h1.s, ci);
        s  = h2.s;
        co = h1.c | h2.c;
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder. Computes a + b + cin one bit per clock, LSB first,
// through a single full-adder bit cell with the carry held in a flop between
// bits. start/busy/done handshake:
//   - start is accepted on a clock edge while the controller is IDLE or DONE;
//     a, b and cin are captured on that same edge and ignored otherwise.
//   - busy is high for the N cycles the bits are being processed.
//   - done pulses for one cycle when sum/cout have just been updated.
// sum/cout only change on the edge that finishes an add, so they hold the
// previous result throughout the following operation.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int             CW   = cnt_width(N);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    state_e         state_q, state_d;
    logic [N-1:0]   ra_q, ra_d;
    logic [N-1:0]   rb_q, rb_d;
    logic [N-1:0]   acc_q, acc_d;
    logic           carry_q, carry_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           bit_s;
    logic           bit_c;
    logic [N-1:0]   acc_shift;

    // The one bit cell always looks at the current LSBs and the stored carry.
    bit_full_adder u_bit (
        .x  (ra_q[0]),
        .y  (rb_q[0]),
        .ci (carry_q),
        .s  (bit_s),
        .co (bit_c)
    );

    // Next-state and datapath updates for the controller.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        // New result bits enter at the MSB so that after N shifts bit 0
        // of the result sits at acc[0]. Written this way so N=1 works too.
        acc_shift        = acc_q >> 1;
        acc_shift[N-1]   = bit_s;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d   = acc_shift;
                ra_d    = ra_q >> 1;
                rb_d    = rb_q >> 1;
                carry_d = bit_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = acc_shift;
                    cout_d  = bit_c;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are decoded from the next state and registered,
        // so they have no combinational path from any input.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // All state, including the registered handshake outputs; async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder (N=4): directed scenarios, an exhaustive operand
// sweep and a random phase, all checked every cycle against a timing/result
// model derived from the accept-edge arithmetic.
module tb_serial_adder;

    localparam int N = 4;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;

    always #5 clk = ~clk;

    serial_adder #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int n_done_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // An accepted start at edge k yields busy after edges k..k+N-1, done
    // after edge k+N, and the result a+b+cin becomes visible at edge k+N.
    // start is accepted only when no add is in flight past its done cycle.
    logic [N:0]   exp_q[$];
    int           op_k   = -1;
    int           edge_n = 0;
    logic [N-1:0] m_sum  = '0;
    logic         m_cout = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_k   = -1;
            edge_n = 0;
            m_sum  = '0;
            m_cout = 1'b0;
            exp_q.delete();
        end else begin
            edge_n++;
            if (op_k >= 0 && edge_n == op_k + N && exp_q.size() > 0)
                {m_cout, m_sum} = exp_q.pop_front();
            if (start && (op_k < 0 || edge_n > op_k + N)) begin
                op_k = edge_n;
                exp_q.push_back({1'b0, a} + {1'b0, b} + (N+1)'(cin));
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic exp_busy;
        logic exp_done;
        exp_busy = (op_k >= 0) && (edge_n >= op_k) && (edge_n <= op_k + N - 1);
        exp_done = (op_k >= 0) && (edge_n == op_k + N);
        check("busy", 32'(busy), 32'(exp_busy));
        check("done", 32'(done), 32'(exp_done));
        check("sum",  32'(sum),  32'(m_sum));
        check("cout", 32'(cout), 32'(m_cout));
        if (done) n_done_seen++;
    end

    // ---------------- driver tasks ----------------
    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present an add request for one edge, then scramble the operands.
    task automatic start_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic cv);
        start = 1'b1;
        a     = av;
        b     = bv;
        cin   = cv;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = N'($urandom);
        b     = N'($urandom);
        cin   = 1'($urandom);
    endtask

    // Wait (bounded) for done; ncyc counts negedges up to and including it.
    task automatic wait_done(input int max_cyc, output int ncyc, output int nbusy);
        ncyc  = 0;
        nbusy = 0;
        repeat (max_cyc) begin
            @(negedge clk);
            ncyc++;
            if (busy) nbusy++;
            if (done) return;
        end
        ncyc = max_cyc + 1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ncyc;
        int nbusy;
        int d0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sum",  32'(sum),  0);
        check("rst_cout", 32'(cout), 0);
        rst_n = 1'b1;
        idle_cycles(2);

        // 1: 7 + 9 + 0 = 16 -> sum 0, cout 1; 4 busy cycles, done on the 5th
        start_op(4'd7, 4'd9, 1'b0);
        wait_done(10, ncyc, nbusy);
        check("s1_latency", 32'(ncyc), 5);
        check("s1_busy_cycles", 32'(nbusy), 4);
        check("s1_sum", 32'(sum), 0);
        check("s1_cout", 32'(cout), 1);
        idle_cycles(2);

        // 2: 3 + 4 = 7, then F + 0 + 1 = 16 while 7 must hold
        start_op(4'd3, 4'd4, 1'b0);
        wait_done(10, ncyc, nbusy);
        check("s2a_sum", 32'(sum), 7);
        check("s2a_cout", 32'(cout), 0);
        idle_cycles(1);
        start_op(4'hF, 4'h0, 1'b1);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            check("s2_hold_sum", 32'(sum), 7);
            check("s2_hold_busy", 32'(busy), 1);
        end
        @(negedge clk);
        check("s2b_done", 32'(done), 1);
        check("s2b_sum", 32'(sum), 0);
        check("s2b_cout", 32'(cout), 1);
        idle_cycles(2);

        // 3: start held through RUN with changing operands is ignored
        d0 = n_done_seen;
        start = 1'b1;
        a = 4'd2;
        b = 4'd3;
        cin = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            a = 4'd1;
            b = 4'd1;
            cin = 1'($urandom);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("s3_sum", 32'(sum), 5);
        check("s3_cout", 32'(cout), 0);
        repeat (6) @(negedge clk);
        check("s3_done_count", 32'(n_done_seen - d0), 1);
        idle_cycles(1);

        // 4: back-to-back restart from the DONE cycle
        start_op(4'd2, 4'd2, 1'b0);
        wait_done(10, ncyc, nbusy);
        check("s4a_sum", 32'(sum), 4);
        start = 1'b1;
        a = 4'd5;
        b = 4'd5;
        cin = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(10, ncyc, nbusy);
        check("s4_latency", 32'(ncyc), 5);
        check("s4_busy_cycles", 32'(nbusy), 4);
        check("s4b_sum", 32'(sum), 10);
        check("s4b_cout", 32'(cout), 0);
        idle_cycles(2);

        // 5: reset pulse after two bits; no done afterwards; next add fine
        start_op(4'd3, 4'd5, 1'b0);
        idle_cycles(2);
        rst_n = 1'b0;
        #1;
        check("s5_busy", 32'(busy), 0);
        check("s5_done", 32'(done), 0);
        check("s5_sum",  32'(sum),  0);
        check("s5_cout", 32'(cout), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        d0 = n_done_seen;
        repeat (8) @(negedge clk);
        check("s5_no_done", 32'(n_done_seen - d0), 0);
        idle_cycles(1);
        start_op(4'd6, 4'd7, 1'b1);
        wait_done(10, ncyc, nbusy);
        check("s5_next_sum", 32'(sum), 14);
        check("s5_next_cout", 32'(cout), 0);
        idle_cycles(2);

        // 6: exhaustive sweep with random gaps (gap 0 = restart from DONE)
        for (int ci = 0; ci < 2; ci++) begin
            for (int ai = 0; ai < 16; ai++) begin
                for (int bi = 0; bi < 16; bi++) begin
                    int gap;
                    gap = $urandom_range(0, 2);
                    if (gap > 0) idle_cycles(gap);
                    start_op(N'(ai), N'(bi), 1'(ci));
                    wait_done(N + 3, ncyc, nbusy);
                    check("s6_latency", 32'(ncyc), N + 1);
                    check("s6_result", 32'({cout, sum}), 32'(ai + bi + ci));
                end
            end
        end
        idle_cycles(2);

        // 7: fully random start/operand traffic, checked by the model only
        repeat (300) begin
            start = 1'($urandom_range(0, 1));
            a     = N'($urandom);
            b     = N'($urandom);
            cin   = 1'($urandom);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        idle_cycles(8);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog: the run is far shorter than this bound.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "timeout");
    end

endmodule
